// File: rtl/zjh_seg_pkg.sv
// Shared types and constants for the multiplexed 8-digit 7-segment scan controller.
// Holds the FSM encoding, the BCD segment table and the leading-zero helper.
package zjh_seg_pkg;

  localparam int DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}; entry n is the pattern for digit value n.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Digit sel is a leading zero when it and every nibble above it are zero.
  function automatic logic lz_blank(input logic [31:0] word, input logic [2:0] sel);
    return (sel != 3'd0) && ((word >> {sel, 2'b00}) == 32'd0);
  endfunction

endpackage

// File: rtl/zjh_bcd7seg.sv
// Combinational BCD to 7-segment decode; non-decimal codes and blank give all segments off.
module zjh_bcd7seg
  import zjh_seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seg = 7'h00;
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/zjh_seg_scan_ctrl.sv
// Eight-digit multiplexed display scanner with shadow-buffered load and anti-ghost gap.
// All outputs are registered; the shown word only changes at a frame boundary or while idle.
module zjh_seg_scan_ctrl
  import zjh_seg_pkg::*;
#(
  parameter int DIV     = 4,
  parameter int GAP_CYC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        lz_en,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  output logic        load_ready,
  output logic [2:0]  dig_sel,
  output logic [7:0]  dig_n,
  output logic [6:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [15:0] GAP_LAST = (GAP_CYC > 0) ? 16'(GAP_CYC - 1) : 16'd0;

  state_t      state, state_nxt;
  logic [2:0]  sel_nxt;
  logic [15:0] presc, presc_nxt;
  logic [15:0] gapc, gapc_nxt;
  logic        new_digit;
  logic [31:0] active, active_nxt, shadow;
  logic        shadow_full, take_shadow;
  logic [7:0]  dig_n_nxt;
  logic [6:0]  seg_nxt, dec_seg;
  logic        frame_done_nxt;
  logic [3:0]  nibble;
  logic        blank;

  assign load_ready  = !shadow_full;
  assign take_shadow = shadow_full && ((state == ST_IDLE) || frame_done);
  assign active_nxt  = take_shadow ? shadow : active;

  // Decode looks at the word and digit that will be live after this edge.
  assign nibble = active_nxt[{sel_nxt, 2'b00} +: 4];
  assign blank  = lz_en && lz_blank(active_nxt, sel_nxt);

  zjh_bcd7seg u_dec (
    .bcd  (nibble),
    .blank(blank),
    .seg  (dec_seg)
  );

  always_comb begin
    state_nxt = state;
    sel_nxt   = dig_sel;
    presc_nxt = presc;
    gapc_nxt  = gapc;
    new_digit = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      sel_nxt   = 3'd0;
      presc_nxt = 16'd0;
      gapc_nxt  = 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_DISP;
          sel_nxt   = 3'd0;
          presc_nxt = 16'd0;
          gapc_nxt  = 16'd0;
          new_digit = 1'b1;
        end
        ST_DISP: begin
          if (presc == DIV_LAST) begin
            presc_nxt = 16'd0;
            if (GAP_CYC > 0) begin
              state_nxt = ST_GAP;
              gapc_nxt  = 16'd0;
            end else begin
              sel_nxt   = dig_sel + 3'd1;
              new_digit = 1'b1;
            end
          end else begin
            presc_nxt = presc + 16'd1;
          end
        end
        ST_GAP: begin
          if (gapc == GAP_LAST) begin
            state_nxt = ST_DISP;
            sel_nxt   = dig_sel + 3'd1;
            gapc_nxt  = 16'd0;
            new_digit = 1'b1;
          end else begin
            gapc_nxt = gapc + 16'd1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          sel_nxt   = 3'd0;
          presc_nxt = 16'd0;
          gapc_nxt  = 16'd0;
        end
      endcase
    end
  end

  // Segments are captured once per digit, so lz_en is effectively sampled per digit.
  always_comb begin
    dig_n_nxt      = 8'hFF;
    seg_nxt        = 7'h00;
    frame_done_nxt = 1'b0;
    if (state_nxt == ST_DISP) begin
      dig_n_nxt = ~(8'd1 << sel_nxt);
      seg_nxt   = new_digit ? dec_seg : seg;
    end
    if (GAP_CYC > 0) begin
      frame_done_nxt = (state_nxt == ST_GAP) && (sel_nxt == 3'd7) && (gapc_nxt == GAP_LAST);
    end else begin
      frame_done_nxt = (state_nxt == ST_DISP) && (sel_nxt == 3'd7) && (presc_nxt == DIV_LAST);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the word registers are
  // plain flops and are reset so a pending load never survives a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dig_sel     <= 3'd0;
      presc       <= 16'd0;
      gapc        <= 16'd0;
      dig_n       <= 8'hFF;
      seg         <= 7'h00;
      frame_done  <= 1'b0;
      active      <= 32'd0;
      shadow      <= 32'd0;
      shadow_full <= 1'b0;
    end else begin
      state      <= state_nxt;
      dig_sel    <= sel_nxt;
      presc      <= presc_nxt;
      gapc       <= gapc_nxt;
      dig_n      <= dig_n_nxt;
      seg        <= seg_nxt;
      frame_done <= frame_done_nxt;
      active     <= active_nxt;
      if (load_valid && load_ready) begin
        shadow      <= load_data;
        shadow_full <= 1'b1;
      end else if (take_shadow) begin
        shadow_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zjh_seg_scan_ctrl.sv
// Self-checking bench for zjh_seg_scan_ctrl (DIV=4, GAP_CYC=1): per-cycle scoreboard of
// {dig_n, seg, frame_done} plus directed handshake, enable and reset checks.
module tb_zjh_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        lz_en;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic [2:0]  dig_sel;
  logic [7:0]  dig_n;
  logic [6:0]  seg;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  zjh_seg_scan_ctrl #(.DIV(4), .GAP_CYC(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lz_en     (lz_en),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .dig_sel   (dig_sel),
    .dig_n     (dig_n),
    .seg       (seg),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  // One frame = 8 x (4 display cycles + 1 gap cycle); frame_done on digit 7's gap.
  task automatic push_frame(input logic [31:0] w, input logic lz);
    logic [31:0] upper;
    logic [6:0]  s;
    for (int k = 0; k < 8; k++) begin
      upper = w >> (4 * k);
      s = ref_seg(upper[3:0]);
      if (lz && (k != 0) && (upper == 32'd0)) s = 7'h00;
      for (int c = 0; c < 4; c++) exp_q.push_back({~(8'd1 << k), s, 1'b0});
      exp_q.push_back({8'hFF, 7'h00, (k == 7)});
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("scan", {16'd0, dig_n, seg, frame_done}, {16'd0, e});
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_word(input logic [31:0] w, output logic [7:0] dig_at_acc);
    int   n;
    logic ok;
    n = 0;
    ok = 1'b0;
    dig_at_acc = 8'h00;
    @(posedge clk);
    #1 load_valid = 1'b1;
    load_data = w;
    while (!ok && n < 500) begin
      @(negedge clk);
      if (load_ready) begin
        ok = 1'b1;
        dig_at_acc = dig_n;
      end else begin
        n++;
      end
    end
    check("load_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1 load_valid = 1'b0;
  endtask

  // Returns just after the edge that enters digit 0, so the next negedge is its first cycle.
  task automatic start_scan(input logic [31:0] w, input logic lz);
    logic [7:0] d;
    @(posedge clk);
    #1 en = 1'b0;
    repeat (2) @(posedge clk);
    load_word(w, d);
    @(posedge clk);
    #1 lz_en = lz;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    int n;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;
    rst = 1'b1;
    en = 1'b0;
    lz_en = 1'b0;
    load_valid = 1'b0;
    load_data = 32'd0;
    #12;
    check("rst_dig_n", dig_n, 8'hFF);
    check("rst_seg", seg, 7'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_dig_sel", dig_sel, 3'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two back-to-back frames of a plain word.
    start_scan(32'h87654321, 1'b0);
    push_frame(32'h87654321, 1'b0);
    push_frame(32'h87654321, 1'b0);
    wait_drain(200);

    // Leading-zero suppression on and off, then an invalid nibble in digit 3.
    start_scan(32'h00000050, 1'b1);
    push_frame(32'h00000050, 1'b1);
    wait_drain(100);
    start_scan(32'h00000050, 1'b0);
    push_frame(32'h00000050, 1'b0);
    wait_drain(100);
    start_scan(32'h8765A321, 1'b0);
    push_frame(32'h8765A321, 1'b0);
    wait_drain(100);

    // Mid-frame load: current frame untouched, second offer held until the frame ends.
    start_scan(32'h87654321, 1'b0);
    push_frame(32'h87654321, 1'b0);
    push_frame(32'h11111111, 1'b0);
    push_frame(32'h22222222, 1'b0);
    repeat (10) @(posedge clk);
    load_word(32'h11111111, d);
    @(negedge clk);
    check("ready_low", load_ready, 1'b0);
    load_word(32'h22222222, d);
    check("acc2_slot", d, 8'hFE);
    wait_drain(200);

    // Drop enable during digit 5, then restart from digit 0.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dig_sel == 3'd5 && dig_n == 8'hDF) && n < 100);
    check("reach_dig5", dig_n, 8'hDF);
    en = 1'b0;
    @(negedge clk);
    check("idle_dig_n", dig_n, 8'hFF);
    check("idle_seg", seg, 7'h00);
    check("idle_dig_sel", dig_sel, 3'd0);
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 push_frame(32'h22222222, 1'b0);
    wait_drain(100);

    // Asynchronous reset mid-display with a pending shadow word.
    load_word(32'h33333333, d);
    @(negedge clk);
    check("ready_pre_rst", load_ready, 1'b0);
    check("disp_pre_rst", {31'd0, (dig_n != 8'hFF)}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_dig_n", dig_n, 8'hFF);
    check("arst_seg", seg, 7'h00);
    check("arst_ready", load_ready, 1'b1);
    en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", load_ready, 1'b1);
    check("post_rst_dig_n", dig_n, 8'hFF);
    @(posedge clk);
    #1 lz_en = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1 push_frame(32'h00000000, 1'b0);
    wait_drain(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zjh_seg_scan_ctrl.md
ZJH_SEG_SCAN_CTRL -- requirements
Module: zjh_seg_scan_ctrl

Interface
REQ-001 Parameter DIV, default 4: clock cycles each digit is driven, legal range 1..65535.
REQ-002 Parameter GAP_CYC, default 1: all-off cycles between digits (anti-ghosting); 0 means no gap.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  scan enable.
REQ-006 lz_en  input  1  leading-zero suppression enable.
REQ-007 load_valid  input  1  new display word offered.
REQ-008 load_data  input  32  eight BCD nibbles; nibble 0 (bits 3:0) is rightmost digit 0.
REQ-009 load_ready  output  1  shadow buffer can accept a word.
REQ-010 dig_sel  output  3  binary index of the digit being driven (74HC138 A-input style).
REQ-011 dig_n  output  8  one-hot active-low digit strobe; bit k low only while digit k is driven.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-high (74HC4511 style).
REQ-013 frame_done  output  1  one-cycle pulse at the end of digit 7's slot.

Function
REQ-014 States: IDLE, DISP, GAP; all outputs registered.
REQ-015 IDLE: dig_n=8'hFF, seg=0; when en=1, go to DISP with dig_sel=0 on the next edge.
REQ-016 DISP: drive digit dig_sel for exactly DIV cycles, then go to GAP (GAP_CYC>0) or straight to DISP with dig_sel+1 (GAP_CYC=0).
REQ-017 GAP: dig_n=8'hFF, seg=0 for exactly GAP_CYC cycles, then DISP with dig_sel+1.
REQ-018 dig_sel wraps 7->0; frame_done pulses in the last cycle of digit 7's slot (last GAP cycle, or last DISP cycle when GAP_CYC=0).
REQ-019 en=0 sampled in any state: next edge goes to IDLE with outputs blanked and dig_sel=0; a restart always begins at digit 0.
REQ-020 Decode: BCD 0-9 to the standard 7-segment patterns (0 -> 7'h3F, 1 -> 7'h06, 8 -> 7'h7F); nibbles 10-15 give seg=0.
REQ-021 Leading-zero suppression: with lz_en=1, digit k (k=7..1) is blanked (seg=0, strobe still asserted) when nibbles k..7 are all zero; digit 0 is never suppressed.
REQ-022 Handshake: a transfer occurs when load_valid && load_ready at a rising edge; the word goes to the shadow register and shadow_full is set.
REQ-023 load_ready = !shadow_full.
REQ-024 The active register takes the shadow word, clearing shadow_full, on the frame_done cycle or on any cycle in IDLE; the displayed word never changes mid-frame.
REQ-025 Only a shadow word that was full before the edge is transferred; a word accepted on the frame_done edge waits for the next frame end.
REQ-026 lz_en is sampled per digit.

Reset
REQ-027 While rst=1: state=IDLE, dig_sel=0, dig_n=8'hFF, seg=0, frame_done=0, active=0, shadow=0, shadow_full=0, load_ready=1, prescale and gap counters=0.
REQ-028 Reset asserted mid-frame blanks outputs immediately (asynchronously) and discards a pending shadow word.

Structure
REQ-029 Package zjh_seg_pkg holds the state encoding constants, the 7-segment pattern table, and the DIGITS=8 constant.
REQ-030 Sub-module zjh_bcd7seg holds the combinational BCD-to-segment decode with a blank input; it is instantiated once on the muxed nibble.
REQ-031 Counter widths are 16 bits for the prescale counter and 16 bits for the gap counter.

Verification (DIV=4, GAP_CYC=1)
REQ-032 Reset, en=1, load 32'h87654321 -> one frame = 40 cycles; digit 0 shows 7'h06 for 4 cycles; dig_n sequence FE,FF,FD,FF,...,7F,FF; frame_done pulses once per 40 cycles.
REQ-033 Load 32'h00000050 with lz_en=1 -> digits 7..2 blank, digit 1 = 7'h6D, digit 0 = 7'h3F; with lz_en=0 digits 7..2 show 7'h3F.
REQ-034 Mid-frame load 32'h11111111 then a second offer 32'h22222222 -> first accepted, load_ready=0 and second held; current frame unchanged; next frame shows 1s; second accepted after that frame_done.
REQ-035 Nibble 4'hA in digit 3 -> seg=0 during digit 3 slot, strobe dig_n=F7 still asserted.
REQ-036 en dropped during digit 5 -> next cycle dig_n=FF, IDLE; en raised -> scan restarts at digit 0.
REQ-037 rst pulsed mid-DISP with shadow full -> outputs blank without a clock edge; after release active=0 and load_ready=1.
